// File: rtl/result_drain.sv
// result_drain: reads a block of result words from BRAM1 and streams each
// word out over a valid/ready interface. It also accumulates the sum of both
// packed products of every word the sink accepts.
module result_drain #(
    parameter int unsigned CNT           = 31,
    parameter int unsigned DWIDTH        = 32,
    parameter int unsigned AWIDTH        = 12,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH     = 48,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [CNT-1:0]       i_num_cnt,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic [AWIDTH-1:0]    addr_b1,
    output logic                 ce_b1,
    output logic                 we_b1,
    output logic [DWIDTH-1:0]    d0_b1,
    input  logic [DWIDTH-1:0]    q0_b1,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DWIDTH-1:0]    m_data,
    output logic                 m_last,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_sum_valid
);

    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned PROD_W = 2 * IN_DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT-1:0]       num_cnt_q, num_cnt_d;
    logic [CNT-1:0]       rd_cnt_q, rd_cnt_d;
    logic [CNT-1:0]       out_cnt_q, out_cnt_d;
    logic                 inflight_q, inflight_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 sum_valid_q, sum_valid_d;
    logic [DWIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [DWIDTH-1:0]    mem_d [FIFO_DEPTH];

    logic              rd_en;
    logic              push;
    logic              pop;
    logic              valid_int;
    logic              last_int;
    logic [DWIDTH-1:0] head;

    // Read-issue credit and stream handshake decode
    always_comb begin
        // Credit uses only registered occupancy, so a pop in this cycle frees nothing yet.
        rd_en     = (state_q == S_RUN) && (rd_cnt_q < num_cnt_q) &&
                    ((fifo_cnt_q + CW'(inflight_q)) < CW'(FIFO_DEPTH));
        push      = inflight_q;
        valid_int = (fifo_cnt_q != '0);
        head      = mem_q[rd_ptr_q];
        pop       = valid_int && m_ready;
        last_int  = valid_int && (out_cnt_q == (num_cnt_q - CNT'(1)));
    end

    // Next-state logic for FSM, counters, FIFO and accumulator
    always_comb begin
        state_d     = state_q;
        num_cnt_d   = num_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        inflight_d  = rd_en;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        acc_d       = acc_q;
        sum_valid_d = sum_valid_q;
        mem_d       = mem_q;

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + CNT'(1);
        end

        // BRAM data arrives one cycle after the chip enable
        if (push) begin
            mem_d[wr_ptr_q] = q0_b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            out_cnt_d = out_cnt_q + CNT'(1);
            acc_d     = acc_q + ACC_WIDTH'(head[PROD_W-1:0])
                              + ACC_WIDTH'(head[2*PROD_W-1:PROD_W]);
        end

        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    num_cnt_d   = i_num_cnt;
                    rd_cnt_d    = '0;
                    out_cnt_d   = '0;
                    inflight_d  = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    fifo_cnt_d  = '0;
                    acc_d       = '0;
                    // An empty run completes immediately with a valid zero sum
                    sum_valid_d = (i_num_cnt == '0);
                    state_d     = (i_num_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && last_int) begin
                    state_d     = S_DONE;
                    sum_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            num_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            acc_q       <= '0;
            sum_valid_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            num_cnt_q   <= num_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            acc_q       <= acc_d;
            sum_valid_q <= sum_valid_d;
            mem_q       <= mem_d;
        end
    end

    // Output drive
    always_comb begin
        o_idle      = (state_q == S_IDLE);
        o_running   = (state_q == S_RUN);
        o_done      = (state_q == S_DONE);
        addr_b1     = rd_cnt_q[AWIDTH-1:0];
        ce_b1       = rd_en;
        we_b1       = 1'b0;
        d0_b1       = '0;
        m_valid     = valid_int;
        m_data      = head;
        m_last      = last_int;
        o_sum       = acc_q;
        o_sum_valid = sum_valid_q;
    end

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: random-backpressure bench for result_drain. It uses a BRAM
// model and a beat-level reference model that is checked every cycle.
module tb_result_drain;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_run;
    logic [30:0] i_num_cnt;
    logic        o_idle, o_running, o_done;
    logic [11:0] addr_b1;
    logic        ce_b1, we_b1;
    logic [31:0] d0_b1;
    logic [31:0] q0_b1 = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;
    logic [47:0] o_sum;
    logic        o_sum_valid;

    result_drain dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .o_idle(o_idle), .o_running(o_running), .o_done(o_done),
        .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d0_b1(d0_b1), .q0_b1(q0_b1),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_sum(o_sum), .o_sum_valid(o_sum_valid)
    );

    always #5 clk = ~clk;

    // BRAM1 model: registered read
    logic [31:0] mem [4096];
    always @(posedge clk) if (ce_b1) q0_b1 <= mem[addr_b1];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state: words expected, reads issued, beats accepted
    int          n_model = 0;
    int          rd_idx = 0;
    int          acc_idx = 0;
    int          max_out = 0;
    logic [47:0] model_sum = '0;
    bit          chk_en = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] got_q[$];
    bit          got_last[$];
    int          ready_mode = 0;

    // Sink ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare against the reference model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_sum", 64'(o_sum), 64'(model_sum));
            chk("m_last_without_valid", 64'(m_last & ~m_valid), 64'd0);
            if (ce_b1) begin
                chk("read_in_range", 64'(rd_idx < n_model), 64'd1);
                chk("addr_b1", 64'(addr_b1), 64'(rd_idx[11:0]));
                rd_idx++;
            end
            if (rd_idx - acc_idx > max_out) max_out = rd_idx - acc_idx;
            chk("outstanding", 64'(rd_idx - acc_idx <= DEPTH), 64'd1);
            if (prev_stall) begin
                chk("stall_valid_held", 64'(m_valid), 64'd1);
                chk("stall_data_held", 64'(m_data), 64'(prev_data));
            end
            if (m_valid) begin
                chk("beat_in_range", 64'(acc_idx < n_model), 64'd1);
                if (acc_idx < n_model) begin
                    chk("m_data", 64'(m_data), 64'(mem[acc_idx]));
                    chk("m_last", 64'(m_last), 64'(acc_idx == n_model - 1));
                end
                if (m_ready) begin
                    model_sum = model_sum + 48'(m_data[15:0]) + 48'(m_data[31:16]);
                    got_q.push_back(m_data);
                    got_last.push_back(m_last);
                    acc_idx++;
                end
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
    end

    task automatic start(input int n);
        @(posedge clk);
        #1;
        i_num_cnt = 31'(n);
        i_run = 1'b1;
        @(posedge clk);
        n_model = n; rd_idx = 0; acc_idx = 0; max_out = 0; model_sum = '0;
        prev_stall = 0; got_q.delete(); got_last.delete(); chk_en = 1;
        #1 i_run = 1'b0;
    endtask

    task automatic wait_first_valid(input string tag);
        int lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, "_first_ce"}, 64'(ce_b1), 64'd1);
            if (m_valid) break;
        end
        chk({tag, "_valid_latency"}, 64'(lat), 64'd3);
    endtask

    task automatic wait_done(input int n, input string tag);
        int cyc = 0;
        bit seen = 0;
        while (cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (o_done) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_beats"}, 64'(acc_idx), 64'(n));
        chk({tag, "_sum_valid"}, 64'(o_sum_valid), 64'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(o_done), 64'd0);
        chk({tag, "_idle_after"}, 64'(o_idle), 64'd1);
        chk({tag, "_sum_valid_hold"}, 64'(o_sum_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"}, 64'(o_idle), 64'd1);
        chk({tag, "_running"}, 64'(o_running), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_ce"}, 64'(ce_b1), 64'd0);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_last"}, 64'(m_last), 64'd0);
        chk({tag, "_sum_valid"}, 64'(o_sum_valid), 64'd0);
        chk({tag, "_sum"}, 64'(o_sum), 64'd0);
        chk({tag, "_addr"}, 64'(addr_b1), 64'd0);
    endtask

    task automatic check_three(input string tag);
        chk({tag, "_count"}, 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk({tag, "_w0"}, 64'(got_q[0]), 64'h0006000C);
            chk({tag, "_w1"}, 64'(got_q[1]), 64'h00010002);
            chk({tag, "_w2"}, 64'(got_q[2]), 64'hFFFF0000);
            chk({tag, "_last_pattern"}, 64'({got_last[2], got_last[1], got_last[0]}), 64'b100);
        end
        chk({tag, "_sum_literal"}, 64'(o_sum), 64'd65556);
    endtask

    initial begin
        int lasts;
        int quiet;
        reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: three words, sink always ready
        mem[0] = 32'h0006000C; mem[1] = 32'h00010002; mem[2] = 32'hFFFF0000;
        ready_mode = 0;
        start(3);
        wait_first_valid("t1");
        wait_done(3, "t1");
        check_three("t1");

        // 2: same data, sink stalled for 10 cycles after the first valid
        ready_mode = 2;
        start(3);
        wait_first_valid("t2");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_stall_data", 64'(m_data), 64'h0006000C);
        end
        ready_mode = 0;
        wait_done(3, "t2");
        check_three("t2");

        // 2b: long stall fills the buffer and must stop reads at full depth
        for (int i = 0; i < 12; i++) mem[i] = $urandom;
        ready_mode = 2;
        start(12);
        repeat (12) @(negedge clk);
        chk("t2b_peak_outstanding", 64'(max_out), 64'(DEPTH));
        ready_mode = 1;
        wait_done(12, "t2b");

        // 3: zero-length run
        start(0);
        @(negedge clk);
        chk("t3_done_next", 64'(o_done), 64'd1);
        chk("t3_sum", 64'(o_sum), 64'd0);
        chk("t3_sum_valid", 64'(o_sum_valid), 64'd1);
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            if (ce_b1 || m_valid) quiet++;
            @(negedge clk);
        end
        chk("t3_no_activity", 64'(quiet), 64'd0);

        // 4: 1024 incrementing words, random backpressure
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0101_0000 + 32'(i) * 32'h0001_0001;
        ready_mode = 1;
        start(1024);
        wait_done(1024, "t4");
        lasts = 0;
        foreach (got_last[i]) if (got_last[i]) lasts++;
        chk("t4_last_count", 64'(lasts), 64'd1);
        if (got_last.size() == 1024) chk("t4_last_on_1023", 64'(got_last[1023]), 64'd1);

        // 5: asynchronous reset mid-run, then a short clean run
        for (int i = 0; i < 20; i++) mem[i] = $urandom;
        start(20);
        repeat (8) @(negedge clk);
        #2;
        reset_n = 1'b0;
        chk_en = 0;
        #1;
        check_reset_outputs("t5_async");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mem[0] = 32'h00030004; mem[1] = 32'h01000010;
        ready_mode = 0;
        start(2);
        wait_done(2, "t5");
        chk("t5_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t5_w0", 64'(got_q[0]), 64'h00030004);
            chk("t5_w1", 64'(got_q[1]), 64'h01000010);
        end
        chk("t5_sum_literal", 64'(o_sum), 64'd279);

        // 6: i_run pulsed mid-run must be ignored
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        ready_mode = 0;
        start(8);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        i_num_cnt = 31'd2;
        i_run = 1'b1;
        @(posedge clk);
        #1 i_run = 1'b0;
        wait_done(8, "t6");
        quiet = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (!o_idle) quiet++;
        end
        chk("t6_stays_idle", 64'(quiet), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
